mul_gh_stream: RTL and testbench

MUL_GH_STREAM -- requirements
Module: mul_gh_stream

---
 rtl/mul_gh_stream.sv | 129 ++++++++++++
 tb/tb_mul_gh_stream.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_gh_stream.sv
// Streaming h*g weighting stage for a WIN x WIN window, with a per-beat bypass path.
// Two-stage pipeline with a single advance enable and an idle-only writable coefficient table.
module mul_gh_stream #(
   parameter int WIN   = 11,
   parameter int LANES = 1,
   parameter int HW    = 7,
   parameter int GW    = 7,
   localparam int N    = WIN * WIN,
   localparam int B    = N / LANES,
   localparam int OW   = HW + GW,
   localparam int IW   = (B > 1) ? $clog2(B) : 1,
   localparam int AW   = (N > 1) ? $clog2(N) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mode,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*HW-1:0]       in_h,
   input  logic [LANES*(OW-1)-1:0]   in_byp,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*OW-1:0]       out_w,
   output logic [IW-1:0]             out_idx,
   output logic                      out_last,
   input  logic                      cfg_we,
   input  logic [AW-1:0]             cfg_addr,
   input  logic [GW-1:0]             cfg_data,
   output logic                      cfg_err
);

   logic [GW-1:0]             coef_q [N];

   logic [IW-1:0]             cnt_q, cnt_d;
   logic                      s1_v_q, s1_mode_q, s1_last_q;
   logic [IW-1:0]             s1_idx_q;
   logic [LANES*HW-1:0]       s1_h_q;
   logic [LANES*GW-1:0]       s1_g_q, g_rd;
   logic [LANES*(OW-1)-1:0]   s1_byp_q;
   logic                      s2_v_q, s2_last_q;
   logic [IW-1:0]             s2_idx_q;
   logic [LANES*OW-1:0]       s2_w_q, w_d;
   logic                      cfg_err_q;
   logic [AW-1:0]             e;

   logic adv, accept, idle, addr_ok, cfg_ok;

   assign adv      = !s2_v_q || out_ready;
   assign in_ready = adv;
   assign accept   = in_valid && adv;
   assign idle     = (cnt_q == '0) && !s1_v_q && !s2_v_q;
   assign addr_ok  = 32'(cfg_addr) < 32'(N);
   // A write colliding with an accepted beat is rejected so the beat sees a consistent table.
   assign cfg_ok   = cfg_we && idle && addr_ok && !accept;

   assign out_valid = s2_v_q;
   assign out_w     = s2_w_q;
   assign out_idx   = s2_idx_q;
   assign out_last  = s2_last_q;
   assign cfg_err   = cfg_err_q;

   always_comb begin
      cnt_d = cnt_q;
      if (accept) cnt_d = (cnt_q == IW'(B - 1)) ? '0 : cnt_q + 1'b1;
   end

   always_comb begin
      g_rd = '0;
      e    = '0;
      for (int k = 0; k < LANES; k++) begin
         e = AW'(cnt_q) * AW'(LANES) + AW'(k);
         if (!mode) g_rd[k*GW +: GW] = coef_q[e];
      end
   end

   always_comb begin
      w_d = '0;
      for (int k = 0; k < LANES; k++) begin
         if (s1_mode_q)
            w_d[k*OW +: OW] = {1'b0, s1_byp_q[k*(OW-1) +: (OW-1)]};
         else
            w_d[k*OW +: OW] = OW'(s1_h_q[k*HW +: HW]) * OW'(s1_g_q[k*GW +: GW]);
      end
   end

   // Table is deliberately outside the reset domain so it survives rst_n.
   always_ff @(posedge clk) begin
      if (cfg_ok) coef_q[cfg_addr] <= cfg_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         s1_v_q    <= 1'b0;
         s1_mode_q <= 1'b0;
         s1_last_q <= 1'b0;
         s1_idx_q  <= '0;
         s1_h_q    <= '0;
         s1_g_q    <= '0;
         s1_byp_q  <= '0;
         s2_v_q    <= 1'b0;
         s2_last_q <= 1'b0;
         s2_idx_q  <= '0;
         s2_w_q    <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         cfg_err_q <= cfg_we && !cfg_ok;
         if (adv) begin
            s1_v_q <= accept;
            if (accept) begin
               s1_mode_q <= mode;
               s1_idx_q  <= cnt_q;
               s1_last_q <= (cnt_q == IW'(B - 1));
               s1_h_q    <= in_h;
               s1_g_q    <= g_rd;
               s1_byp_q  <= in_byp;
            end
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
               s2_w_q    <= w_d;
               s2_idx_q  <= s1_idx_q;
               s2_last_q <= s1_last_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_mul_gh_stream.sv
// Scoreboard bench for mul_gh_stream at default parameters (121-beat window, one lane).
module tb_mul_gh_stream;
   localparam int N  = 121;
   localparam int B  = 121;
   localparam int HW = 7;
   localparam int GW = 7;
   localparam int OW = 14;
   localparam int IW = 7;
   localparam int AW = 7;

   logic clk = 1'b0;
   logic rst_n, mode, in_valid, in_ready, out_valid, out_ready, out_last;
   logic cfg_we, cfg_err;
   logic [HW-1:0]   in_h;
   logic [OW-2:0]   in_byp;
   logic [OW-1:0]   out_w;
   logic [IW-1:0]   out_idx;
   logic [AW-1:0]   cfg_addr;
   logic [GW-1:0]   cfg_data;

   int errors = 0;
   int checks = 0;
   logic [GW-1:0] tb_tab [N];
   int mcnt = 0;
   logic [OW-1:0] q_w [$];
   int            q_idx [$];
   logic          q_last [$];

   logic          hold_pend = 1'b0;
   logic [OW-1:0] hold_w;
   logic [IW-1:0] hold_idx;

   mul_gh_stream dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
      .in_h(in_h), .in_byp(in_byp), .out_valid(out_valid), .out_ready(out_ready),
      .out_w(out_w), .out_idx(out_idx), .out_last(out_last),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   // Output monitor: pops the scoreboard on every handshake and checks stall stability.
   always @(negedge clk) begin
      logic [OW-1:0] ew;
      int            ei;
      logic          el;
      if (rst_n === 1'b1) begin
         if (hold_pend) begin
            checks++;
            if (out_w !== hold_w || out_idx !== hold_idx || out_valid !== 1'b1) begin
               errors++;
               $display("FAIL stall_hold: out_w=%h idx=%0d valid=%b, required out_w=%h idx=%0d valid=1",
                        out_w, out_idx, out_valid, hold_w, hold_idx);
            end
         end
         hold_pend = out_valid && !out_ready;
         hold_w    = out_w;
         hold_idx  = out_idx;
         if (out_valid && out_ready) begin
            checks++;
            if (q_w.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: out_w=%h idx=%0d, required no output", out_w, out_idx);
            end else begin
               ew = q_w.pop_front();
               ei = q_idx.pop_front();
               el = q_last.pop_front();
               if (out_w !== ew || int'(out_idx) != ei || out_last !== el) begin
                  errors++;
                  $display("FAIL scoreboard: out_w=%h idx=%0d last=%b, required out_w=%h idx=%0d last=%b",
                           out_w, out_idx, out_last, ew, ei, el);
               end
            end
         end
      end else begin
         hold_pend = 1'b0;
      end
   end

   // Entered and left just after a rising edge.
   task automatic send_beat(input logic [HW-1:0] h, input logic m, input logic [OW-2:0] byp);
      int n = 0;
      in_valid = 1'b1; in_h = h; mode = m; in_byp = byp;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL send_timeout: in_ready=%b, required 1 within 200 cycles", in_ready);
      end else begin
         q_w.push_back(m ? {1'b0, byp} : OW'(h) * OW'(tb_tab[mcnt]));
         q_idx.push_back(mcnt);
         q_last.push_back(mcnt == B - 1);
         mcnt = (mcnt == B - 1) ? 0 : mcnt + 1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (q_w.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (q_w.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: pending=%0d, required 0", q_w.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic cfg_write(input int addr, input logic [GW-1:0] data);
      cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_data = data;
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #23;
      checks++;
      if (out_valid !== 1'b0 || out_w !== '0 || out_idx !== '0 || out_last !== 1'b0 || cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: valid=%b w=%h idx=%0d last=%b err=%b, required all 0",
                  out_valid, out_w, out_idx, out_last, cfg_err);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
      end
   endtask

   task automatic load_table();
      for (int i = 0; i < N; i++) begin
         tb_tab[i] = GW'($urandom_range(0, 127));
         cfg_write(i, tb_tab[i]);
      end
   endtask

   task automatic test_basic();
      cfg_write(0, 7'h04);
      tb_tab[0] = 7'h04;
      checks++;
      if (cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL idle_write_err: cfg_err=%b, required 0", cfg_err);
      end
      send_beat(7'd100, 1'b0, '0);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_early: out_valid=%b one cycle after accept, required 0", out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_w !== 14'd400 || out_idx !== '0) begin
         errors++;
         $display("FAIL latency_two: valid=%b w=%0d idx=%0d, required valid=1 w=400 idx=0",
                  out_valid, out_w, out_idx);
      end
      wait_drain();
   endtask

   task automatic test_back_to_back();
      int last_seen = 0;
      for (int i = 0; i < B; i++) send_beat(HW'($urandom_range(0, 127)), 1'b0, '0);
      wait_drain();
      send_beat(HW'($urandom_range(0, 127)), 1'b0, '0);
      wait_drain();
      last_seen = mcnt;
      checks++;
      if (last_seen != 2) begin
         errors++;
         $display("FAIL wrap_count: model index=%0d, required 2", last_seen);
      end
   endtask

   task automatic test_stall();
      fork
         begin
            for (int i = 0; i < 30; i++) send_beat(HW'($urandom_range(0, 127)), 1'b0, '0);
         end
         begin
            repeat (8) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
               errors++;
               $display("FAIL stall_ready: in_ready=%b out_valid=%b, required 0 and 1", in_ready, out_valid);
            end
            out_ready = 1'b1;
         end
      join
      wait_drain();
   endtask

   task automatic test_bypass();
      send_beat(HW'($urandom_range(0, 127)), 1'b1, 13'h1ABC);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_w !== 14'h1ABC) begin
         errors++;
         $display("FAIL bypass_value: valid=%b w=%h, required valid=1 w=1abc", out_valid, out_w);
      end
      wait_drain();
      for (int i = 0; i < 12; i++)
         send_beat(HW'($urandom_range(0, 127)), 1'(i % 3 == 0), OW'($urandom_range(0, 8191)) - 1'b0);
      wait_drain();
   endtask

   task automatic test_cfg();
      logic [GW-1:0] old;
      while (mcnt != 3) send_beat(HW'($urandom_range(0, 127)), 1'b0, '0);
      wait_drain();
      cfg_write(5, ~tb_tab[5]);
      checks++;
      if (cfg_err !== 1'b1) begin
         errors++;
         $display("FAIL busy_write_err: cfg_err=%b, required 1", cfg_err);
      end
      @(posedge clk); #1;
      checks++;
      if (cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL err_pulse_len: cfg_err=%b second cycle, required 0", cfg_err);
      end
      while (mcnt != 0) send_beat(HW'($urandom_range(0, 127)), 1'b0, '0);
      wait_drain();
      cfg_write(N, 7'h55);
      checks++;
      if (cfg_err !== 1'b1) begin
         errors++;
         $display("FAIL range_write_err: cfg_err=%b, required 1", cfg_err);
      end
      @(posedge clk); #1;
      old = tb_tab[0];
      cfg_we = 1'b1; cfg_addr = '0; cfg_data = ~old;
      send_beat(7'd127, 1'b0, '0);
      cfg_we = 1'b0;
      checks++;
      if (cfg_err !== 1'b1) begin
         errors++;
         $display("FAIL collide_write_err: cfg_err=%b, required 1", cfg_err);
      end
      wait_drain();
   endtask

   task automatic test_reset_mid();
      while (mcnt != 50) send_beat(HW'($urandom_range(0, 127)), 1'b0, '0);
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_idx !== '0) begin
         errors++;
         $display("FAIL mid_reset: out_valid=%b idx=%0d, required 0 and 0", out_valid, out_idx);
      end
      q_w.delete(); q_idx.delete(); q_last.delete();
      mcnt = 0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_beat(7'd77, 1'b0, '0);
      send_beat(7'd3, 1'b0, '0);
      wait_drain();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      mode = 1'b0; in_valid = 1'b0; in_h = '0; in_byp = '0; out_ready = 1'b1;
      cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      test_reset();
      load_table();
      test_basic();
      test_back_to_back();
      test_stall();
      test_bypass();
      test_cfg();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
